// File: rtl/hue_pkg.sv
// Shared definitions for the hue pipeline: function codes, fixed-point constants
// and the stage0 FSM encoding.
package hue_pkg;

  localparam int FRAC_W_DEF = 6;

  localparam logic [1:0] FN_GREY = 2'd0;
  localparam logic [1:0] FN_R    = 2'd1;
  localparam logic [1:0] FN_G    = 2'd2;
  localparam logic [1:0] FN_B    = 2'd3;

  // Degrees in unsigned Q.FRAC_W_DEF; hue_stage1 scales and offsets with these.
  localparam logic [15:0] FP_60  = 16'(60  << FRAC_W_DEF);
  localparam logic [15:0] FP_120 = 16'(120 << FRAC_W_DEF);
  localparam logic [15:0] FP_240 = 16'(240 << FRAC_W_DEF);
  localparam logic [15:0] FP_360 = 16'(360 << FRAC_W_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_DIV  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/hue_divider.sv
// Serial restoring divider producing Q_BITS quotient bits, MSB first, one per cycle.
// The caller guarantees dividend >> Q_BITS < divisor, so upper quotient bits are zero.
module hue_divider #(
  parameter int DVD_W  = 14,
  parameter int Q_BITS = 7
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [DVD_W-1:0]        dividend_i,
  input  logic [DVD_W-Q_BITS:0]   divisor_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [Q_BITS-1:0]       quotient_o
);

  localparam int DSR_W = DVD_W - Q_BITS + 1;
  localparam int CNT_W = $clog2(Q_BITS + 1);

  logic [DSR_W-1:0]  rem_q, rem_d;
  logic [DSR_W-1:0]  den_q;
  logic [Q_BITS-1:0] quo_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic [DSR_W:0]    trial, diff;
  logic              fit;

  // quo_q doubles as the shift register feeding the low dividend bits in.
  always_comb begin
    trial = {rem_q, quo_q[Q_BITS-1]};
    diff  = trial - {1'b0, den_q};
    fit   = (trial >= {1'b0, den_q});
    rem_d = fit ? diff[DSR_W-1:0] : trial[DSR_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q  <= '0;
      den_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= {1'b0, dividend_i[DVD_W-1:Q_BITS]};
      quo_q  <= dividend_i[Q_BITS-1:0];
      den_q  <= divisor_i;
      cnt_q  <= CNT_W'(Q_BITS - 1);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= {quo_q[Q_BITS-2:0], fit};
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) busy_q <= 1'b0;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = busy_q && (cnt_q == '0);
  assign quotient_o = quo_q;

endmodule

// File: rtl/hue_stage0.sv
// Hue front end: max/min/delta, sector select and signed sector ratio numerator/delta.
//   state | meaning
//   IDLE  | ready for a pixel
//   PREP  | max/min/sector computed, divider loaded
//   DIV   | one quotient bit per cycle
//   OUT   | result registered to outputs, o_valid next cycle
module hue_stage0 import hue_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [DATA_W-1:0] i_r,
  input  logic [DATA_W-1:0] i_g,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [15:0]       o_data,
  output logic [1:0]        o_function,
  output logic [DATA_W-1:0] o_max,
  output logic [DATA_W-1:0] o_delta,
  output logic              o_valid
);

  localparam int Q_BITS = FRAC_W + 1;

  state_t state_q, state_d;

  logic [DATA_W-1:0] r_q, g_q, b_q;
  logic [DATA_W-1:0] max_q, delta_q;
  logic [1:0]        fn_q;
  logic              neg_q;

  logic [15:0]       out_data_q;
  logic [1:0]        out_fn_q;
  logic [DATA_W-1:0] out_max_q, out_delta_q;
  logic              out_valid_q;

  logic                     accept, div_start, div_busy, div_done;
  logic [Q_BITS-1:0]        div_quo, quo_eff;
  logic [DATA_W+FRAC_W-1:0] div_dividend;

  logic [DATA_W-1:0] max_c, min_c, delta_c, mag_c;
  logic [1:0]        fn_c;
  logic signed [DATA_W:0] num_c;
  logic              neg_c;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_PREP;
      ST_PREP: state_d = ST_DIV;
      ST_DIV:  if (div_done || !div_busy) state_d = ST_OUT;
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_ready   = (state_q == ST_IDLE) && i_rstn;
    accept    = i_valid && o_ready;
    div_start = (state_q == ST_PREP);
  end

  // Tie priority R > G > B falls out of the >= ordering.
  always_comb begin
    if (r_q >= g_q && r_q >= b_q) begin
      max_c = r_q;
      min_c = (g_q < b_q) ? g_q : b_q;
      fn_c  = FN_R;
      num_c = $signed({1'b0, g_q}) - $signed({1'b0, b_q});
    end else if (g_q >= b_q) begin
      max_c = g_q;
      min_c = (r_q < b_q) ? r_q : b_q;
      fn_c  = FN_G;
      num_c = $signed({1'b0, b_q}) - $signed({1'b0, r_q});
    end else begin
      max_c = b_q;
      min_c = (r_q < g_q) ? r_q : g_q;
      fn_c  = FN_B;
      num_c = $signed({1'b0, r_q}) - $signed({1'b0, g_q});
    end
    delta_c = max_c - min_c;
    if (delta_c == '0) fn_c = FN_GREY;
    neg_c        = num_c[DATA_W];
    mag_c        = DATA_W'(neg_c ? -num_c : num_c);
    div_dividend = {mag_c, {FRAC_W{1'b0}}};
  end

  hue_divider #(
    .DVD_W  (DATA_W + FRAC_W),
    .Q_BITS (Q_BITS)
  ) u_div (
    .clk_i      (i_clk),
    .rst_ni     (i_rstn),
    .start_i    (div_start),
    .dividend_i (div_dividend),
    .divisor_i  (delta_c),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_quo)
  );

  // A zero divisor leaves garbage in the divider; grey pixels report 0.
  assign quo_eff = (fn_q == FN_GREY) ? '0 : div_quo;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      max_q       <= '0;
      delta_q     <= '0;
      fn_q        <= FN_GREY;
      neg_q       <= 1'b0;
      out_data_q  <= '0;
      out_fn_q    <= FN_GREY;
      out_max_q   <= '0;
      out_delta_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        r_q <= i_r;
        g_q <= i_g;
        b_q <= i_b;
      end
      if (state_q == ST_PREP) begin
        max_q   <= max_c;
        delta_q <= delta_c;
        fn_q    <= fn_c;
        neg_q   <= neg_c;
      end
      out_valid_q <= (state_q == ST_OUT);
      if (state_q == ST_OUT) begin
        out_data_q  <= {neg_q && (quo_eff != '0), 15'(quo_eff)};
        out_fn_q    <= fn_q;
        out_max_q   <= max_q;
        out_delta_q <= delta_q;
      end
    end
  end

  assign o_data     = out_data_q;
  assign o_function = out_fn_q;
  assign o_max      = out_max_q;
  assign o_delta    = out_delta_q;
  assign o_valid    = out_valid_q;

endmodule

// File: tb/tb_hue_stage0.sv
// Directed bench for hue_stage0: sector/ratio vectors, latency, streaming and mid-run reset.
module tb_hue_stage0;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic [7:0]  i_r, i_g, i_b;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] o_data;
  logic [1:0]  o_function;
  logic [7:0]  o_max, o_delta;
  logic        o_valid;

  int checks   = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  hue_stage0 #(.DATA_W(8), .FRAC_W(6)) dut (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_r        (i_r),
    .i_g        (i_g),
    .i_b        (i_b),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_data     (o_data),
    .o_function (o_function),
    .o_max      (o_max),
    .o_delta    (o_delta),
    .o_valid    (o_valid)
  );

  task automatic test_reset();
    i_rstn = 1'b0; i_valid = 1'b0; i_r = 8'd0; i_g = 8'd0; i_b = 8'd0;
    @(posedge i_clk); #1;
    checks++;
    if (o_valid !== 1'b0 || o_data !== 16'h0 || o_function !== 2'd0 || o_max !== 8'd0 || o_delta !== 8'd0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b data=%h fn=%0d max=%0d delta=%0d, want all 0",
               o_valid, o_data, o_function, o_max, o_delta);
    end
    checks++;
    if (o_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready: got %b want 0", o_ready);
    end
    @(posedge i_clk); #1;
    i_rstn = 1'b1; #1;
    checks++;
    if (o_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_ready: got %b want 1", o_ready);
    end
  endtask

  task automatic test_sectors();
    logic [7:0]  vr[7]  = '{8'd255, 8'd255, 8'd0,   8'd255, 8'd50,  8'd200, 8'd100};
    logic [7:0]  vg[7]  = '{8'd0,   8'd255, 8'd255, 8'd0,   8'd100, 8'd250, 8'd100};
    logic [7:0]  vb[7]  = '{8'd0,   8'd0,   8'd255, 8'd128, 8'd150, 8'd10,  8'd100};
    logic [1:0]  ef[7]  = '{2'd1,   2'd1,   2'd2,   2'd1,   2'd3,   2'd2,   2'd0};
    logic [15:0] ed[7]  = '{16'h0000, 16'h0040, 16'h0040, 16'h8020, 16'h8020, 16'h8032, 16'h0000};
    logic [7:0]  em[7]  = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd150, 8'd250, 8'd100};
    logic [7:0]  edl[7] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd100, 8'd240, 8'd0};
    for (int v = 0; v < 7; v++) begin
      int  lat = 0;
      bit  seen = 1'b0;
      bit  early_ready = 1'b0;
      i_r = vr[v]; i_g = vg[v]; i_b = vb[v]; i_valid = 1'b1;
      checks++;
      if (o_ready !== 1'b1) begin
        failures++;
        $display("FAIL vec%0d_ready_before: got %b want 1", v, o_ready);
      end
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      i_r = 8'($urandom); i_g = 8'($urandom); i_b = 8'($urandom);
      for (int c = 1; c <= 15 && !seen; c++) begin
        @(posedge i_clk); #1;
        if (o_valid === 1'b1) begin
          seen = 1'b1;
          lat  = c;
        end else if (o_ready === 1'b1) begin
          early_ready = 1'b1;
        end
      end
      checks++;
      if (lat != 9) begin
        failures++;
        $display("FAIL vec%0d_latency: got %0d want 9", v, lat);
      end
      checks++;
      if (early_ready) begin
        failures++;
        $display("FAIL vec%0d_busy_ready: got ready=1 while busy, want 0", v);
      end
      checks++;
      if (o_function !== ef[v] || o_data !== ed[v] || o_max !== em[v] || o_delta !== edl[v]) begin
        failures++;
        $display("FAIL vec%0d_result: got fn=%0d data=%h max=%0d delta=%0d want fn=%0d data=%h max=%0d delta=%0d",
                 v, o_function, o_data, o_max, o_delta, ef[v], ed[v], em[v], edl[v]);
      end
      @(posedge i_clk); #1;
      checks++;
      if (o_valid !== 1'b0 || o_data !== ed[v] || o_function !== ef[v]) begin
        failures++;
        $display("FAIL vec%0d_hold: got valid=%b data=%h fn=%0d want valid=0 data=%h fn=%0d",
                 v, o_valid, o_data, o_function, ed[v], ef[v]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  pr[3]  = '{8'd40,  8'd10,  8'd100};
    logic [7:0]  pg[3]  = '{8'd20,  8'd200, 8'd50};
    logic [7:0]  pb[3]  = '{8'd220, 8'd50,  8'd80};
    logic [1:0]  ef[3]  = '{2'd3, 2'd2, 2'd1};
    logic [15:0] ed[3]  = '{16'h0006, 16'h000D, 16'h8026};
    logic [7:0]  em[3]  = '{8'd220, 8'd200, 8'd100};
    logic [7:0]  edl[3] = '{8'd200, 8'd190, 8'd50};
    int acc[3]  = '{-100, -100, -100};
    int vcyc[3] = '{-200, -200, -200};
    int idx = 0;
    int nres = 0;
    bit adv = 1'b0;
    bit prev_v = 1'b0;
    i_r = pr[0]; i_g = pg[0]; i_b = pb[0]; i_valid = 1'b1;
    for (int k = 0; k < 45; k++) begin
      if (o_valid === 1'b1) begin
        checks++;
        if (prev_v) begin
          failures++;
          $display("FAIL b2b_valid_pulse: got o_valid high two cycles at step %0d, want one", k);
        end
        if (nres < 3) begin
          vcyc[nres] = k;
          checks++;
          if (o_function !== ef[nres] || o_data !== ed[nres] || o_max !== em[nres] || o_delta !== edl[nres]) begin
            failures++;
            $display("FAIL b2b_result%0d: got fn=%0d data=%h max=%0d delta=%0d want fn=%0d data=%h max=%0d delta=%0d",
                     nres, o_function, o_data, o_max, o_delta, ef[nres], ed[nres], em[nres], edl[nres]);
          end
        end
        nres++;
      end
      prev_v = o_valid;
      if (adv) begin
        adv = 1'b0;
        idx++;
        if (idx < 3) begin
          i_r = pr[idx]; i_g = pg[idx]; i_b = pb[idx];
        end else begin
          i_valid = 1'b0;
        end
      end
      if (o_ready === 1'b1 && idx < 3) begin
        acc[idx] = k + 1;
        adv = 1'b1;
      end
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    checks++;
    if (nres != 3) begin
      failures++;
      $display("FAIL b2b_count: got %0d results want 3", nres);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (acc[i+1] - acc[i] != 10) begin
        failures++;
        $display("FAIL b2b_spacing%0d: got %0d cycles want 10", i, acc[i+1] - acc[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (vcyc[i] - acc[i] != 9) begin
        failures++;
        $display("FAIL b2b_latency%0d: got %0d want 9", i, vcyc[i] - acc[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int  lat = 0;
    bit  seen = 1'b0;
    int  stray = 0;
    i_r = 8'd255; i_g = 8'd0; i_b = 8'd128; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rstn = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_data !== 16'h0 || o_function !== 2'd0 || o_max !== 8'd0 || o_delta !== 8'd0 || o_ready !== 1'b0) begin
      failures++;
      $display("FAIL midreset_outputs: got valid=%b data=%h fn=%0d max=%0d delta=%0d ready=%b want all 0",
               o_valid, o_data, o_function, o_max, o_delta, o_ready);
    end
    repeat (2) @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
    #1;
    checks++;
    if (o_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_ready: got %b want 1", o_ready);
    end
    for (int c = 0; c < 14; c++) begin
      @(posedge i_clk); #1;
      if (o_valid !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL midreset_stray_valid: got %0d pulses want 0", stray);
    end
    i_r = 8'd10; i_g = 8'd200; i_b = 8'd50; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    for (int c = 1; c <= 15 && !seen; c++) begin
      @(posedge i_clk); #1;
      if (o_valid === 1'b1) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    checks++;
    if (lat != 9 || o_function !== 2'd2 || o_data !== 16'h000D || o_max !== 8'd200 || o_delta !== 8'd190) begin
      failures++;
      $display("FAIL postreset_pixel: got lat=%0d fn=%0d data=%h max=%0d delta=%0d want lat=9 fn=2 data=000d max=200 delta=190",
               lat, o_function, o_data, o_max, o_delta);
    end
  endtask

  initial begin
    test_reset();
    test_sectors();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
